axrm16_prod_accum: RTL and testbench
====================================

Name: axrm16_prod_accum

Overview:
- Downstream stage for the 16x16 approximate recursive multiplier.
- Consumes the multiplier's 32-bit unsigned product stream through a valid/ready handshake.
- Accumulates products into a dot-product sum over a vector of up to VEC_LEN beats, or fewer if terminated early by in_last.
- Presents the registered sum, beat count and an overflow flag to the next stage through an output valid/ready handshake.

Parameters:
- PROD_W, 32, product width; matches the multiplier's result output.
- ACC_W, 40, accumulator width; must be >= PROD_W.
- VEC_LEN, 8, maximum beats per vector; range 1..255.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  product beat valid.
- in_ready  out  1  block can accept a beat.
- in_prod  in  PROD_W  unsigned product from multiplier.
- in_last  in  1  final beat of the current vector; sampled only on an accepted beat.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  ACC_W  accumulated (saturated) sum.
- out_count  out  8  number of beats accumulated in this vector.
- out_ovf  out  1  saturation occurred during this vector.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=ACC, acc=0, cnt=0, ovf=0, out_valid=0, out_sum=0, out_count=0, out_ovf=0, in_ready=1 (in_ready is decoded from state).
- States:
  - ACC: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Beat acceptance: a beat is accepted when in_valid && in_ready at a rising edge.
- Arithmetic per accepted beat:
  - sum_ext = {1'b0,acc} + zero-extended in_prod, computed at ACC_W+1 bits.
  - If sum_ext[ACC_W]=1: acc <= all-ones and ovf <= 1. Once saturated, acc stays all-ones for the rest of the vector.
  - Otherwise acc <= sum_ext[ACC_W-1:0].
  - cnt <= cnt+1.
- ACC -> DONE transition: taken on an accepted beat when (cnt+1 == VEC_LEN) or in_last=1.
  - On the same edge, out_sum, out_count and out_ovf load the updated acc, cnt+1 and ovf values.
  - out_valid is therefore high the cycle after the final beat is accepted. Latency is 1 cycle.
- DONE -> ACC transition: taken on out_valid && out_ready.
  - acc, cnt and ovf clear to 0.
  - out_sum, out_count and out_ovf hold their values but are not meaningful while out_valid=0.
- Output stability: while out_valid=1 and out_ready=0, out_sum, out_count and out_ovf are held stable. in_valid is ignored in DONE.
- Throughput: at most one vector per (beats+1) cycles. There is no overlap between a vector's output handshake and the next vector's input.
- VEC_LEN=1: every accepted beat produces a result equal to in_prod, with out_count=1.
- in_last coinciding with cnt+1==VEC_LEN: a single completion; no empty vector follows.
- Empty vector: impossible. DONE is only entered on an accepted beat.
- Reset asserted mid-vector or in DONE: the partial sum and any pending result are discarded and all registers return to reset values on that edge. rst has priority over every handshake.
- Width rule: out_count is 8 bits, and VEC_LEN <= 255 guarantees no count wrap.

Test Plan:
- Full vector, default params: 8 beats of in_prod=32'h0000_FFFF with in_valid held high and out_ready=1 -> out_valid high one cycle after beat 8; out_sum=40'h0_0007_FFF8, out_count=8, out_ovf=0. in_ready low for exactly one cycle.
- Early termination: 3 beats of values 5, 7, 11 with in_last on beat 3 -> out_sum=23, out_count=3, out_ovf=0. The next vector then starts from acc=0.
- Saturation with ACC_W=34, VEC_LEN=8: 8 beats of 32'hFFFF_FFFF.
  - After beat 4, acc=34'h3_FFFF_FFFC.
  - Beat 5 saturates.
  - Result: out_sum=34'h3_FFFF_FFFF, out_ovf=1, out_count=8.
- Backpressure: complete a vector of 2 beats (10, 20), then hold out_ready=0 for 5 cycles while driving in_valid=1 -> out_valid, out_sum=30 and out_count=2 are stable. in_ready=0, and no beats are accepted. Raise out_ready -> ACC next cycle.
- Input bubbles: 4 beats of 100 with in_valid toggling 1,0,1,0,... -> out_sum=400, out_count=4. Only in_valid && in_ready beats are counted.
- Reset mid-operation:
  - Accept 2 beats of 50, then pulse rst for 1 cycle -> in_ready=1, out_valid=0.
  - Then a full 8-beat vector of 1 -> out_sum=8, out_count=8. Nothing from the discarded beats is carried over.

Source files
------------

// File: rtl/axrm16_prod_accum.sv
// Saturating dot-product accumulator for the approximate multiplier's product stream; result is registered
// one cycle after the final beat, and no input is taken while a result waits for out_ready.
module axrm16_prod_accum #(
  parameter int PROD_W  = 32,
  parameter int ACC_W   = 40,
  parameter int VEC_LEN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [7:0]        out_count,
  output logic              out_ovf
);

  localparam logic [7:0] VEC_LEN_C = 8'(VEC_LEN);

  typedef enum logic {ACC = 1'b0, DONE = 1'b1} state_t;

  typedef struct packed {
    logic [ACC_W-1:0] sum;
    logic [7:0]       count;
    logic             ovf;
  } res_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [7:0]       cnt, cnt_inc;
  logic             ovf, ovf_nxt;
  logic [ACC_W:0]   sum_ext;
  logic             accept, final_beat, release_res;
  res_t             res;

  assign accept      = in_valid && in_ready;
  assign release_res = out_valid && out_ready;
  assign cnt_inc     = cnt + 8'd1;
  assign final_beat  = accept && ((cnt_inc == VEC_LEN_C) || in_last);

  // One spare bit catches the carry; once saturated, acc is all-ones and any add re-saturates.
  assign sum_ext = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
  assign acc_nxt = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
  assign ovf_nxt = ovf | sum_ext[ACC_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACC;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (final_beat)  state_nxt = DONE;
      DONE:    if (release_res) state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  always_comb begin
    in_ready  = (state == ACC);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      res <= '0;
    end else begin
      if (accept) begin
        acc <= acc_nxt;
        cnt <= cnt_inc;
        ovf <= ovf_nxt;
      end
      if (final_beat) begin
        res <= '{sum: acc_nxt, count: cnt_inc, ovf: ovf_nxt};
      end
      if (release_res) begin
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end
    end
  end

  assign out_sum   = res.sum;
  assign out_count = res.count;
  assign out_ovf   = res.ovf;

endmodule

// File: tb/tb_axrm16_prod_accum.sv
// Three accumulator instances (default, ACC_W=34, VEC_LEN=1) driven by directed and random vectors;
// expected results come from summing each vector's products and clamping to the accumulator range.
module tb_axrm16_prod_accum;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv   [3];
  logic        il   [3];
  logic        ordy [3];
  logic [31:0] ip   [3];
  logic        ir   [3];
  logic        ov   [3];
  logic        of   [3];
  logic [7:0]  oc   [3];
  logic [39:0] os0, os2;
  logic [33:0] os1;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] q_prod [$];
  bit          q_last [$];

  axrm16_prod_accum dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_prod(ip[0]), .in_last(il[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_sum(os0), .out_count(oc[0]), .out_ovf(of[0]));

  axrm16_prod_accum #(.ACC_W(34), .VEC_LEN(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_prod(ip[1]), .in_last(il[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_sum(os1), .out_count(oc[1]), .out_ovf(of[1]));

  axrm16_prod_accum #(.ACC_W(40), .VEC_LEN(1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_prod(ip[2]), .in_last(il[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_sum(os2), .out_count(oc[2]), .out_ovf(of[2]));

  function automatic logic [63:0] get_sum(input int d);
    case (d)
      0:       return {24'd0, os0};
      1:       return {30'd0, os1};
      default: return {24'd0, os2};
    endcase
  endfunction

  function automatic int acc_w(input int d);
    return (d == 1) ? 34 : 40;
  endfunction

  function automatic int vec_len(input int d);
    return (d == 2) ? 1 : 8;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input int n, input logic [31:0] v, input bit last_on_final);
    q_prod.delete();
    q_last.delete();
    for (int i = 0; i < n; i++) begin
      q_prod.push_back(v);
      q_last.push_back(last_on_final && (i == n - 1));
    end
  endtask

  // Called right after a rising edge; returns at the falling edge where in_ready is seen high.
  task automatic wait_rdy(input int d, input string tag);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ir[d]) break;
    end
    chk({tag, "_accept"}, 64'(ir[d]), 64'd1);
  endtask

  // Sends q_prod/q_last as one vector, checks the result, holds it 'hold' extra cycles, then releases.
  task automatic run_vec(input int d, input bit bubble, input int hold, input string tag);
    longint unsigned total = 0;
    longint unsigned maxv;
    logic [63:0] esum;
    bit eovf;
    int n = q_prod.size();
    maxv = (64'd1 << acc_w(d)) - 64'd1;
    foreach (q_prod[i]) total += 64'(q_prod[i]);
    eovf = (total > maxv);
    esum = eovf ? maxv : total;

    @(posedge clk); #1;
    ordy[d] = (hold == 0);
    for (int i = 0; i < n; i++) begin
      iv[d] = 1'b1;
      ip[d] = q_prod[i];
      il[d] = q_last[i];
      wait_rdy(d, tag);
      @(posedge clk); #1;
      if (i == n - 1) begin
        ip[d] = 32'hDEAD_BEEF;
        il[d] = 1'b1;
      end else if (bubble) begin
        iv[d] = 1'b0;
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    chk({tag, "_valid"}, 64'(ov[d]), 64'd1);
    chk({tag, "_sum"}, get_sum(d), esum);
    chk({tag, "_count"}, 64'(oc[d]), 64'(n));
    chk({tag, "_ovf"}, 64'(of[d]), 64'(eovf));
    chk({tag, "_ready_low"}, 64'(ir[d]), 64'd0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_hold_valid"}, 64'(ov[d]), 64'd1);
      chk({tag, "_hold_sum"}, get_sum(d), esum);
      chk({tag, "_hold_count"}, 64'(oc[d]), 64'(n));
      chk({tag, "_hold_ready"}, 64'(ir[d]), 64'd0);
    end
    ordy[d] = 1'b1;
    @(posedge clk); #1;
    iv[d] = 1'b0;
    il[d] = 1'b0;
    @(negedge clk);
    chk({tag, "_released"}, 64'(ov[d]), 64'd0);
    chk({tag, "_ready_back"}, 64'(ir[d]), 64'd1);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; il[d] = 1'b0; ordy[d] = 1'b1; ip[d] = '0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(ir[0]), 64'd1);
    chk("rst_valid", 64'(ov[0]), 64'd0);
    chk("rst_sum", get_sum(0), 64'd0);
    chk("rst_count", 64'(oc[0]), 64'd0);
    chk("rst_ovf", 64'(of[0]), 64'd0);

    fill(8, 32'h0000_FFFF, 1'b0);  run_vec(0, 1'b0, 0, "full8");
    q_prod = '{32'd5, 32'd7, 32'd11};  q_last = '{1'b0, 1'b0, 1'b1};
    run_vec(0, 1'b0, 0, "early3");
    fill(1, 32'd42, 1'b1);  run_vec(0, 1'b0, 0, "after_early");
    fill(4, 32'hFFFF_FFFF, 1'b1);  run_vec(1, 1'b0, 0, "sat_pre4");
    fill(8, 32'hFFFF_FFFF, 1'b0);  run_vec(1, 1'b0, 0, "sat8");
    q_prod = '{32'd10, 32'd20};  q_last = '{1'b0, 1'b1};
    run_vec(0, 1'b0, 5, "bp");
    fill(4, 32'd100, 1'b1);  run_vec(0, 1'b1, 0, "bubble");
    fill(1, 32'd77, 1'b0);  run_vec(2, 1'b0, 0, "len1");
    fill(1, 32'hFFFF_FFFF, 1'b1);  run_vec(2, 1'b0, 1, "len1_last");
    fill(8, 32'd3, 1'b1);  run_vec(0, 1'b0, 0, "last_at_len");

    // Reset after two accepted beats: partial sum must be dropped.
    @(posedge clk); #1;
    iv[0] = 1'b1; ip[0] = 32'd50; il[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 iv[0] = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 64'(ir[0]), 64'd1);
    chk("midrst_valid", 64'(ov[0]), 64'd0);
    fill(8, 32'd1, 1'b0);  run_vec(0, 1'b0, 0, "post_rst");

    // Reset while a result is pending.
    @(posedge clk); #1;
    ordy[0] = 1'b0; iv[0] = 1'b1; ip[0] = 32'd9; il[0] = 1'b1;
    @(posedge clk); #1 iv[0] = 1'b0; il[0] = 1'b0;
    @(negedge clk);
    chk("donerst_pre_valid", 64'(ov[0]), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; ordy[0] = 1'b1;
    @(negedge clk);
    chk("donerst_valid", 64'(ov[0]), 64'd0);
    chk("donerst_ready", 64'(ir[0]), 64'd1);
    chk("donerst_sum", get_sum(0), 64'd0);
    fill(2, 32'd6, 1'b1);  run_vec(0, 1'b0, 0, "post_donerst");

    for (int r = 0; r < 24; r++) begin
      int d = r % 3;
      int n = $urandom_range(vec_len(d), 1);
      q_prod.delete();
      q_last.delete();
      for (int i = 0; i < n; i++) begin
        logic [31:0] v = $urandom();
        if (d == 1 && $urandom_range(1, 0) == 1) v = v | 32'hF000_0000;
        q_prod.push_back(v);
        q_last.push_back((i == n - 1) && ((n < vec_len(d)) || ($urandom_range(1, 0) == 1)));
      end
      run_vec(d, 1'($urandom_range(1, 0)), $urandom_range(3, 0), $sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
